// File: rtl/bubble_sort_engine_if.sv
// bubble_sort_engine_if
//   Bundles the load, control, display-read and status signals of
//   bubble_sort_engine. The clock and reset stay plain ports on the engine.
//   Parameters:
//     W  - element width in bits
//     AW - address width (2**AW must cover the element count)
//   Modports:
//     master - the side that loads, starts, paces and reads (controller/display)
//     slave  - the sort engine itself
interface bubble_sort_engine_if #(
  parameter int W  = 8,
  parameter int AW = 5
);
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          start;
  logic          step_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [4:0]    pass_count;
  logic [9:0]    swap_count;

  modport master (
    output ld_en, ld_addr, ld_data, start, step_en, rd_addr,
    input  rd_data, busy, done, pass_count, swap_count
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, step_en, rd_addr,
    output rd_data, busy, done, pass_count, swap_count
  );
endinterface

// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine
//   Holds the array rendered by the VGA bar-graph stage and sorts it in place
//   with a bubble sort, one compare-and-swap per cycle with step_en high, so
//   every swap stays visible on screen.
//   Parameters:
//     N  - element count (2..32)
//     W  - element width in bits (unsigned)
//     AW - address width, 2**AW >= N
//   Ports:
//     clk   - single clock for all state
//     reset - synchronous, active-low; reloads the array with N-1-i
//     bus   - slave side of bubble_sort_engine_if:
//             ld_en/ld_addr/ld_data  write port (IDLE or DONE only)
//             start                  begins a sort (IDLE or DONE only)
//             step_en                permits one compare-and-swap this cycle
//             rd_addr/rd_data        asynchronous read, 0 beyond N-1
//             busy/done              sorting / finished-until-next-start-or-load
//             pass_count/swap_count  statistics of the current or last sort
module bubble_sort_engine #(
  parameter int N  = 32,
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  bubble_sort_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem [N];
  logic [AW-1:0] j_q, j_p1;
  logic          swapped_q;
  logic [4:0]    pass_q;
  logic [9:0]    swap_q;

  logic [W-1:0]  cur_a, cur_b;
  logic          do_swap, end_pass, last_pass, pass_clean;
  logic          load_ok, start_ok, step_ok;

  // The pair under comparison; j never exceeds N-2 while sorting.
  assign j_p1      = j_q + AW'(1);
  assign cur_a     = mem[j_q];
  assign cur_b     = mem[j_p1];
  assign do_swap   = cur_a > cur_b;  // strict: equal values never move
  // The last pass_count positions already hold their final values.
  assign end_pass  = (32'(j_q) + 32'(pass_q)) == (N - 2);
  assign last_pass = (32'(pass_q) + 1) == (N - 1);
  // The swap made on this very step counts toward the pass.
  assign pass_clean = !(swapped_q || do_swap);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    load_ok  = 1'b0;
    start_ok = 1'b0;
    step_ok  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        load_ok = bus.ld_en && (32'(bus.ld_addr) < N);
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = SORT;
        end else if (bus.ld_en) begin
          // Any new data invalidates a finished result.
          state_d = IDLE;
        end
      end
      SORT: begin
        if (bus.step_en) begin
          step_ok = 1'b1;
          if (end_pass && (pass_clean || last_pass)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the array is plain registers, so it is reset like any other state;
  // the descending reload gives the display a worst-case sort to show.
  // NOTE: all sequential state uses non-blocking assignments so the swap
  // below reads both old values before either is overwritten.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= W'(N - 1 - i);
      j_q       <= '0;
      swapped_q <= 1'b0;
      pass_q    <= '0;
      swap_q    <= '0;
    end else begin
      if (load_ok) mem[bus.ld_addr] <= bus.ld_data;
      if (start_ok) begin
        j_q       <= '0;
        swapped_q <= 1'b0;
        pass_q    <= '0;
        swap_q    <= '0;
      end else if (step_ok) begin
        if (do_swap) begin
          mem[j_q]  <= cur_b;
          mem[j_p1] <= cur_a;
          swapped_q <= 1'b1;
          swap_q    <= swap_q + 10'd1;
        end
        if (end_pass) begin
          pass_q <= pass_q + 5'd1;
          if (!(pass_clean || last_pass)) begin
            j_q       <= '0;
            swapped_q <= 1'b0;
          end
        end else begin
          j_q <= j_p1;
        end
      end
    end
  end

  assign bus.rd_data    = (32'(bus.rd_addr) < N) ? mem[bus.rd_addr] : '0;
  assign bus.busy       = (state_q == SORT);
  assign bus.done       = (state_q == DONE);
  assign bus.pass_count = pass_q;
  assign bus.swap_count = swap_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// tb_bubble_sort_engine
//   Directed bench for bubble_sort_engine. A textbook nested-loop bubble sort
//   produces the expected array/counters after every step; a compare process
//   checks the DUT against that trace on every busy cycle, and literal values
//   pin both the model and the end results. A second N=2 instance covers the
//   smallest build and out-of-range addresses.
`timescale 1ns/1ps
module tb_bubble_sort_engine;
  localparam int N    = 32;
  localparam int W    = 8;
  localparam int AW   = 5;
  localparam int HALF = 50;

  typedef logic [N-1:0][W-1:0] arr_t;
  typedef struct packed {
    arr_t       a;
    logic [4:0] p;
    logic [9:0] s;
    logic       busy;
  } snap_t;

  logic clk = 1'b0;
  logic reset;
  always #HALF clk = ~clk;

  bubble_sort_engine_if #(.W(W), .AW(AW)) bus ();
  bubble_sort_engine #(.N(N), .W(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bubble_sort_engine_if #(.W(W), .AW(2)) bus2 ();
  bubble_sort_engine #(.N(2), .W(W), .AW(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int    errors = 0;
  int    checks = 0;
  snap_t trace[$];
  int    idx = 0;
  bit    armed = 1'b0;

  task automatic check(input string name, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Textbook bubble sort with early exit; one snapshot per compare step.
  task automatic build_trace(input arr_t init);
    arr_t         a;
    logic [W-1:0] t;
    int           swaps;
    bit           sw, fin;
    snap_t        e;
    a = init;
    swaps = 0;
    trace.delete();
    e.a = a; e.p = '0; e.s = '0; e.busy = 1'b1;
    trace.push_back(e);
    for (int p = 0; p < N - 1; p++) begin
      sw = 1'b0;
      for (int j = 0; j < N - 1 - p; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          swaps++;
          sw = 1'b1;
        end
        fin    = (j == N - 2 - p) && (!sw || p == N - 2);
        e.a    = a;
        e.p    = 5'((j == N - 2 - p) ? p + 1 : p);
        e.s    = 10'(swaps);
        e.busy = !fin;
        trace.push_back(e);
      end
      if (!sw) break;
    end
  endtask

  task automatic read_dut(output arr_t r);
    for (int i = 0; i < N; i++) begin
      bus.rd_addr = AW'(i);
      #1;
      r[i] = bus.rd_data;
    end
  endtask

  // Compare process: inputs change at negedge, so step_en/busy are sampled
  // just before the rising edge and the result is checked just after it.
  initial begin
    bit    pre_busy, pre_step;
    arr_t  got;
    snap_t e;
    forever begin
      @(negedge clk);
      #(HALF - 5);
      pre_busy = bus.busy;
      pre_step = bus.step_en;
      @(posedge clk);
      #1;
      if (armed && pre_busy) begin
        if (pre_step) idx++;
        if (idx >= trace.size()) begin
          check("steps_within_trace", idx, trace.size() - 1);
          armed = 1'b0;
        end else begin
          e = trace[idx];
          read_dut(got);
          check("step_array", got, e.a);
          check("step_pass", bus.pass_count, e.p);
          check("step_swaps", bus.swap_count, e.s);
          check("step_busy", bus.busy, e.busy);
          check("step_done", bus.done, !e.busy);
          if (!e.busy) armed = 1'b0;
        end
      end
      check("busy_done_exclusive", bus.busy & bus.done, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic start_sort(input arr_t init);
    build_trace(init);
    @(negedge clk);
    bus.start = 1'b1;
    idx = 0;
    armed = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Loads the whole array; optionally raises start alongside the last write.
  task automatic load_array(input arr_t a, input bit with_start);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.ld_en   = 1'b1;
      bus.ld_addr = AW'(i);
      bus.ld_data = a[i];
      if (with_start && i == N - 1) begin
        build_trace(a);
        bus.start = 1'b1;
        idx = 0;
        armed = 1'b1;
      end
    end
    @(negedge clk);
    bus.ld_en = 1'b0;
    bus.start = 1'b0;
  endtask

  // Pulses step_en once every 'every' cycles until done or budget runs out.
  // At step index inject_at a load and a start are driven for one cycle.
  task automatic run_sort(input int every, input int budget, input int inject_at);
    int n = 0;
    bit injected = 1'b0;
    forever begin
      @(negedge clk);
      bus.ld_en = 1'b0;
      bus.start = 1'b0;
      if (bus.done || n >= budget) break;
      if (!injected && idx == inject_at) begin
        bus.ld_en   = 1'b1;
        bus.ld_addr = AW'(3);
        bus.ld_data = 8'hAA;
        bus.start   = 1'b1;
        injected    = 1'b1;
      end
      bus.step_en = ((n % every) == 0);
      n++;
    end
    bus.step_en = 1'b0;
    check("sort_finished", bus.done, 1);
    check("busy_after_done", bus.busy, 0);
    armed = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arr_t desc, asc, sevens, got;
    logic [1:0][W-1:0] two;

    for (int i = 0; i < N; i++) begin
      desc[i]   = W'(N - 1 - i);
      asc[i]    = W'(i);
      sevens[i] = (i == N - 1) ? W'(3) : W'(7);
    end

    reset = 1'b0;
    bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 0; bus.step_en = 0; bus.rd_addr = '0;
    bus2.ld_en = 0; bus2.ld_addr = '0; bus2.ld_data = '0;
    bus2.start = 0; bus2.step_en = 0; bus2.rd_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state.
    read_dut(got);
    check("reset_array", got, desc);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_pass", bus.pass_count, 0);
    check("reset_swaps", bus.swap_count, 0);

    // Model pinned against hand-derived totals.
    build_trace(desc);
    check("model_desc_steps", trace.size() - 1, 496);
    check("model_desc_swaps", trace[$].s, 496);
    check("model_desc_passes", trace[$].p, 31);
    build_trace(sevens);
    check("model_sevens_swaps", trace[$].s, 31);
    check("model_sevens_passes", trace[$].p, 31);

    // N=2 build: reset reload, ignored out-of-range load, one-step sort.
    for (int i = 0; i < 2; i++) begin
      bus2.rd_addr = 2'(i); #1; two[i] = bus2.rd_data;
    end
    check("n2_reset_array", two, {8'd0, 8'd1});
    @(negedge clk); bus2.ld_en = 1; bus2.ld_addr = 2'd0; bus2.ld_data = 8'd5;
    @(negedge clk); bus2.ld_addr = 2'd1; bus2.ld_data = 8'd2;
    @(negedge clk); bus2.ld_addr = 2'd2; bus2.ld_data = 8'd9;
    @(negedge clk); bus2.ld_en = 0; bus2.start = 1;
    @(negedge clk); bus2.start = 0; bus2.step_en = 1;
    @(negedge clk); bus2.step_en = 0;
    for (int i = 0; i < 2; i++) begin
      bus2.rd_addr = 2'(i); #1; two[i] = bus2.rd_data;
    end
    check("n2_sorted", two, {8'd5, 8'd2});
    check("n2_done", bus2.done, 1);
    check("n2_busy", bus2.busy, 0);
    check("n2_swaps", bus2.swap_count, 1);
    check("n2_passes", bus2.pass_count, 1);
    bus2.rd_addr = 2'd3; #1;
    check("n2_rd_out_of_range3", bus2.rd_data, 0);
    bus2.rd_addr = 2'd2; #1;
    check("n2_rd_out_of_range2", bus2.rd_data, 0);

    // Default descending array, step_en held high.
    start_sort(desc);
    run_sort(1, 600, -1);
    check("desc_steps", idx, 496);
    read_dut(got);
    check("desc_final_array", got, asc);
    check("desc_swaps", bus.swap_count, 496);
    check("desc_passes", bus.pass_count, 31);

    // A load in DONE clears done; ascending data sorts in one clean pass.
    load_array(asc, 1'b0);
    check("load_clears_done", bus.done, 0);
    start_sort(asc);
    run_sort(1, 100, -1);
    check("asc_steps", idx, 31);
    read_dut(got);
    check("asc_final_array", got, asc);
    check("asc_swaps", bus.swap_count, 0);
    check("asc_passes", bus.pass_count, 1);

    // Equal values never swap; lone small value walks down one slot per pass.
    // The start shares its cycle with the final write.
    load_array(sevens, 1'b1);
    run_sort(1, 600, -1);
    read_dut(got);
    check("sevens_elem0", got[0], 3);
    check("sevens_elem31", got[N-1], 7);
    check("sevens_swaps", bus.swap_count, 31);
    check("sevens_passes", bus.pass_count, 31);
    check("sevens_steps", idx, 496);

    // Paced at one step in four; holds on idle cycles are checked per cycle.
    do_reset();
    start_sort(desc);
    run_sort(4, 2100, -1);
    check("paced_steps", idx, 496);
    read_dut(got);
    check("paced_final_array", got, asc);
    check("paced_swaps", bus.swap_count, 496);

    // Load and start during SORT are ignored.
    do_reset();
    start_sort(desc);
    run_sort(1, 600, 100);
    check("inject_steps", idx, 496);
    read_dut(got);
    check("inject_final_array", got, asc);
    check("inject_swaps", bus.swap_count, 496);

    // Reset in the middle of a second sort aborts and reloads.
    start_sort(asc);
    repeat (10) begin
      @(negedge clk);
      bus.step_en = 1'b1;
    end
    check("midsort_busy", bus.busy, 1);
    bus.step_en = 1'b0;
    armed = 1'b0;
    do_reset();
    @(negedge clk);
    read_dut(got);
    check("abort_array", got, desc);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_pass", bus.pass_count, 0);
    check("abort_swaps", bus.swap_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
